// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Definitions shared by the hazard controller, its interface and the
// datapath top:
//   - FSM state encoding (ST_RUN / ST_HALT)
//   - default performance-counter width
//   - stage enable bundle, ordered {PC, IF_ID, ID_EX, EX_MEM, MEM_WB}
package pipeline_pkg;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam int CNT_W_DEF = 32;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_en_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
// Bundles the hazard controller's request inputs, its stage enable/clear
// outputs and the debug-visible status and counters.
//   Requests : Load_Use, Branch_Taken, Mem_Busy, Halt, Go
//   Controls : PC_EN, IF_ID_EN, IF_ID_CLR, ID_EX_EN, ID_EX_CLR, EX_MEM_EN, MEM_WB_EN
//   Status   : Halted, Cycle_Count, Stall_Count, Flush_Count (CNT_W bits)
// Modports: master = pipeline/debug side, slave = controller side.
interface pipeline_hazard_ctrl_if
  import pipeline_pkg::*;
#(parameter int CNT_W = CNT_W_DEF);

  logic             Load_Use;
  logic             Branch_Taken;
  logic             Mem_Busy;
  logic             Halt;
  logic             Go;

  logic             PC_EN;
  logic             IF_ID_EN;
  logic             IF_ID_CLR;
  logic             ID_EX_EN;
  logic             ID_EX_CLR;
  logic             EX_MEM_EN;
  logic             MEM_WB_EN;

  logic             Halted;
  logic [CNT_W-1:0] Cycle_Count;
  logic [CNT_W-1:0] Stall_Count;
  logic [CNT_W-1:0] Flush_Count;

  modport master (
    output Load_Use, Branch_Taken, Mem_Busy, Halt, Go,
    input  PC_EN, IF_ID_EN, IF_ID_CLR, ID_EX_EN, ID_EX_CLR, EX_MEM_EN, MEM_WB_EN,
    input  Halted, Cycle_Count, Stall_Count, Flush_Count
  );

  modport slave (
    input  Load_Use, Branch_Taken, Mem_Busy, Halt, Go,
    output PC_EN, IF_ID_EN, IF_ID_CLR, ID_EX_EN, ID_EX_CLR, EX_MEM_EN, MEM_WB_EN,
    output Halted, Cycle_Count, Stall_Count, Flush_Count
  );

endinterface

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active-low (clears count)
//   inc   : count-enable for this cycle
//   cnt   : current count (W bits)
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline. Turns load-use,
// taken-branch, memory-wait and syscall-halt requests into stage enables
// and bubble clears, and keeps saturating cycle/stall/flush counters.
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active-low (pipeline frozen while low)
//   hz    : request/control/status bundle (slave side)
//
//   state   | meaning
//   --------+-------------------------------------------
//   ST_RUN  | normal issue, hazard priority applies
//   ST_HALT | pipeline frozen until a Go pulse
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  hz
);

  logic [0:0] state_q, state_d;
  stage_en_t  en;
  logic       if_id_clr;
  logic       id_ex_clr;
  logic       run;
  logic       cyc_inc;
  logic       stall_inc;
  logic       flush_inc;

  // Reset gates everything off combinationally, not just at the next edge.
  assign run = rst_n && (state_q == ST_RUN);

  always_comb begin
    state_d   = state_q;
    en        = '0;
    if_id_clr = 1'b0;
    id_ex_clr = 1'b0;
    cyc_inc   = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (run) begin
      cyc_inc = 1'b1;
      if (hz.Mem_Busy) begin
        // Full freeze; other requests are held by their sources.
        stall_inc = 1'b1;
      end else if (hz.Halt) begin
        // Let older instructions retire, squash the halting one after EX.
        en.id_ex  = 1'b1;
        en.ex_mem = 1'b1;
        en.mem_wb = 1'b1;
        id_ex_clr = 1'b1;
        state_d   = ST_HALT;
      end else if (hz.Branch_Taken) begin
        // Any coincident Load_Use comes from a wrong-path instruction.
        en        = '1;
        if_id_clr = 1'b1;
        id_ex_clr = 1'b1;
        flush_inc = 1'b1;
      end else if (hz.Load_Use) begin
        en.id_ex  = 1'b1;
        en.ex_mem = 1'b1;
        en.mem_wb = 1'b1;
        id_ex_clr = 1'b1;
        stall_inc = 1'b1;
      end else begin
        en = '1;
      end
    end else if (rst_n && hz.Go) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  assign hz.PC_EN     = en.pc;
  assign hz.IF_ID_EN  = en.if_id;
  assign hz.IF_ID_CLR = if_id_clr;
  assign hz.ID_EX_EN  = en.id_ex;
  assign hz.ID_EX_CLR = id_ex_clr;
  assign hz.EX_MEM_EN = en.ex_mem;
  assign hz.MEM_WB_EN = en.mem_wb;
  assign hz.Halted    = (state_q == ST_HALT);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cyc_inc),
    .cnt   (hz.Cycle_Count)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (hz.Stall_Count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .cnt   (hz.Flush_Count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Drives a 32-bit-counter and a 4-bit-counter controller with identical
// stimulus (directed scenarios, then random) and compares both against a
// behavioural model of the stall/flush rules and saturating counters.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) if32 ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  if4  ();

  pipeline_hazard_ctrl #(.CNT_W(32)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if32.slave)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if4.slave)
  );

  int checks = 0;
  int errors = 0;

  // Control vector order: {PC_EN, IF_ID_EN, IF_ID_CLR, ID_EX_EN, ID_EX_CLR, EX_MEM_EN, MEM_WB_EN}
  localparam logic [6:0] C_FREEZE = 7'b000_0_0_0_0;
  localparam logic [6:0] C_RETIRE = 7'b000_1_1_1_1;  // halt cycle and load-use bubble
  localparam logic [6:0] C_FLUSH  = 7'b111_1_1_1_1;
  localparam logic [6:0] C_NORMAL = 7'b110_1_0_1_1;

  bit     m_halted;
  longint m_cyc32, m_stl32, m_fl32;
  longint m_cyc4,  m_stl4,  m_fl4;

  function automatic longint sat_inc(longint v, int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (v < lim) ? v + 1 : v;
  endfunction

  function automatic logic [6:0] exp_ctrl(bit r, bit lu, bit bt, bit mb, bit ht);
    if (!r || m_halted || mb) return C_FREEZE;
    if (ht)                   return C_RETIRE;
    if (bt)                   return C_FLUSH;
    if (lu)                   return C_RETIRE;
    return C_NORMAL;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(bit r, bit lu, bit bt, bit mb, bit ht, bit go);
    logic [6:0] e;
    rst_n             = r;
    if32.Load_Use     = lu;  if4.Load_Use     = lu;
    if32.Branch_Taken = bt;  if4.Branch_Taken = bt;
    if32.Mem_Busy     = mb;  if4.Mem_Busy     = mb;
    if32.Halt         = ht;  if4.Halt         = ht;
    if32.Go           = go;  if4.Go           = go;
    @(negedge clk);
    e = exp_ctrl(r, lu, bt, mb, ht);
    chk("ctrl32", 64'({if32.PC_EN, if32.IF_ID_EN, if32.IF_ID_CLR, if32.ID_EX_EN,
                       if32.ID_EX_CLR, if32.EX_MEM_EN, if32.MEM_WB_EN}), 64'(e));
    chk("ctrl4",  64'({if4.PC_EN, if4.IF_ID_EN, if4.IF_ID_CLR, if4.ID_EX_EN,
                       if4.ID_EX_CLR, if4.EX_MEM_EN, if4.MEM_WB_EN}), 64'(e));
    chk("halted32", 64'(if32.Halted), 64'(m_halted));
    chk("halted4",  64'(if4.Halted),  64'(m_halted));
    chk("cycle32",  64'(if32.Cycle_Count), m_cyc32);
    chk("stall32",  64'(if32.Stall_Count), m_stl32);
    chk("flush32",  64'(if32.Flush_Count), m_fl32);
    chk("cycle4",   64'(if4.Cycle_Count),  m_cyc4);
    chk("stall4",   64'(if4.Stall_Count),  m_stl4);
    chk("flush4",   64'(if4.Flush_Count),  m_fl4);
    @(posedge clk);
    if (!r) begin
      m_halted = 1'b0;
      m_cyc32 = 0; m_stl32 = 0; m_fl32 = 0;
      m_cyc4  = 0; m_stl4  = 0; m_fl4  = 0;
    end else if (m_halted) begin
      if (go) m_halted = 1'b0;
    end else begin
      m_cyc32 = sat_inc(m_cyc32, 32);
      m_cyc4  = sat_inc(m_cyc4, 4);
      if (mb || (!ht && !bt && lu)) begin
        m_stl32 = sat_inc(m_stl32, 32);
        m_stl4  = sat_inc(m_stl4, 4);
      end
      if (!mb && !ht && bt) begin
        m_fl32 = sat_inc(m_fl32, 32);
        m_fl4  = sat_inc(m_fl4, 4);
      end
      if (!mb && ht) m_halted = 1'b1;
    end
    #1;
  endtask

  initial begin
    m_halted = 1'b0;
    m_cyc32 = 0; m_stl32 = 0; m_fl32 = 0;
    m_cyc4  = 0; m_stl4  = 0; m_fl4  = 0;
    rst_n = 1'b0;
    if32.Load_Use = 1'b1; if32.Branch_Taken = 1'b0; if32.Mem_Busy = 1'b0;
    if32.Halt = 1'b0; if32.Go = 1'b0;
    if4.Load_Use = 1'b1; if4.Branch_Taken = 1'b0; if4.Mem_Busy = 1'b0;
    if4.Halt = 1'b0; if4.Go = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with Load_Use asserted, then two load-use bubbles.
    repeat (3) step(0, 1, 0, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("stall_after_2_bubbles", 64'(if32.Stall_Count), 64'd2);

    // Branch with simultaneous load-use: flush wins.
    step(1, 1, 1, 0, 0, 0);

    // Memory wait over a pending branch, then the branch resolves.
    repeat (3) step(1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Halt, sit frozen with noisy inputs, resume on Go.
    step(1, 0, 0, 0, 1, 0);
    repeat (10) step(1, 1, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1);
    repeat (2) step(1, 0, 0, 0, 0, 0);

    // Halt blocked by Mem_Busy, entered once the memory is ready.
    repeat (2) step(1, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);

    // Go while running has no effect.
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);

    // Narrow counters saturate, then a single-cycle reset mid-run.
    step(0, 0, 0, 0, 0, 0);
    repeat (20) step(1, 0, 0, 0, 0, 0);
    chk("cycle4_saturated", 64'(if4.Cycle_Count), 64'hF);
    step(0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 3)  == 0,
           $urandom_range(0, 4)  == 0,
           $urandom_range(0, 4)  == 0,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 5)  == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
